prod_accum: RTL and testbench

- Downstream consumer of the 4-bit multiplier's 8-bit product.
- Accumulates a burst of LEN products into a dot-product sum, then presents the sum on a valid/ready output port and holds it until it is taken.
- Gives the combinational multiplier a registered, handshaked MAC back-end, so products can be summed over several cycles.

---
 rtl/mult_pkg.sv | 15 +
 rtl/prod_accum_if.sv | 38 +++
 rtl/prod_accum.sv | 113 +++++++++++
 tb/tb_prod_accum.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the 4x4 multiplier and its product accumulator.
//   OPND_W     : operand width of the multiplier
//   PROD_W_DEF : default width of the multiplier product
//   state_e    : accumulator control states
package mult_pkg;

    localparam int OPND_W     = 4;
    localparam int PROD_W_DEF = 2 * OPND_W;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/prod_accum_if.sv
// Product-in / result-out handshake bundle of the product accumulator.
//   in_valid/in_ready/prod     : product stream into the accumulator
//   out_valid/out_ready        : completed-burst result handshake
//   acc_out/ovf                : burst sum and sticky overflow flag
// slave  : accumulator side
// master : producer/consumer side
interface prod_accum_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              ovf;

    modport slave (
        input  in_valid,
        input  prod,
        input  out_ready,
        output in_ready,
        output out_valid,
        output acc_out,
        output ovf
    );

    modport master (
        output in_valid,
        output prod,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  acc_out,
        input  ovf
    );
endinterface

// File: rtl/prod_accum.sv
// Product accumulator: sums LEN unsigned products into an ACC_W-bit total,
// then presents the total on a valid/ready port until it is taken.
//   CLK  : rising-edge clock
//   RST  : synchronous active-high reset (highest priority)
//   clr  : synchronous burst abort while accumulating; ignored while holding
//   bus  : prod_accum_if slave (in_valid/in_ready/prod,
//          out_valid/out_ready/acc_out/ovf)
// in_ready and out_valid are pure decodes of the state register, so no input
// reaches them combinationally.
module prod_accum
    import mult_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = 12,
    parameter int LEN    = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr,
    prod_accum_if.slave   bus
);

    localparam int               CNT_W  = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);

    state_e             state_r;
    state_e             state_s;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   acc_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               ovf_r;
    logic               ovf_s;
    logic [ACC_W-1:0]   acc_out_r;
    logic [ACC_W-1:0]   acc_out_s;
    logic [ACC_W:0]     sum_s;

    // One extra bit on the adder captures the carry out of the accumulator.
    assign sum_s = {1'b0, acc_r} + (ACC_W + 1)'(bus.prod);

    // Next-state and datapath decode for the accumulate/hold controller.
    always_comb begin
        state_s   = state_r;
        acc_s     = acc_r;
        cnt_s     = cnt_r;
        ovf_s     = ovf_r;
        acc_out_s = acc_out_r;
        case (state_r)
            ACCUM: begin
                if (clr) begin
                    // Abort wins over a same-cycle product.
                    acc_s = '0;
                    cnt_s = '0;
                    ovf_s = 1'b0;
                end else if (bus.in_valid) begin
                    acc_s = sum_s[ACC_W-1:0];
                    cnt_s = cnt_r + CNT_W'(1);
                    ovf_s = ovf_r | sum_s[ACC_W];
                    if (cnt_r == LAST_C) begin
                        state_s   = HOLD;
                        acc_out_s = sum_s[ACC_W-1:0];
                    end else begin
                        state_s   = ACCUM;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    // Result taken; nothing is accepted on this edge, giving
                    // a one-cycle bubble before the next burst.
                    state_s = ACCUM;
                    acc_s   = '0;
                    cnt_s   = '0;
                    ovf_s   = 1'b0;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s   = ACCUM;
                acc_s     = '0;
                cnt_s     = '0;
                ovf_s     = 1'b0;
                acc_out_s = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ACCUM;
            acc_r     <= '0;
            cnt_r     <= '0;
            ovf_r     <= 1'b0;
            acc_out_r <= '0;
        end else begin
            state_r   <= state_s;
            acc_r     <= acc_s;
            cnt_r     <= cnt_s;
            ovf_r     <= ovf_s;
            acc_out_r <= acc_out_s;
        end
    end

    assign bus.in_ready  = (state_r == ACCUM);
    assign bus.out_valid = (state_r == HOLD);
    assign bus.acc_out   = acc_out_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: one instance with LEN=4 (bus a) and one
// with LEN=32 (bus b). Expected burst results are queued as bursts are driven
// and compared whenever a result is handed over on the output port.
module tb_prod_accum;

    typedef struct {
        logic [11:0] acc;
        logic        ovf;
    } exp_t;

    logic CLK;
    logic RST;
    logic clr_a;
    logic clr_b;
    int   n_vec;
    int   n_err;
    exp_t q_a[$];
    exp_t q_b[$];

    prod_accum_if #(.PROD_W(8), .ACC_W(12)) a_if ();
    prod_accum_if #(.PROD_W(8), .ACC_W(12)) b_if ();

    prod_accum #(.PROD_W(8), .ACC_W(12), .LEN(4)) u_dut_a (
        .CLK (CLK),
        .RST (RST),
        .clr (clr_a),
        .bus (a_if.slave)
    );

    prod_accum #(.PROD_W(8), .ACC_W(12), .LEN(32)) u_dut_b (
        .CLK (CLK),
        .RST (RST),
        .clr (clr_b),
        .bus (b_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_a(input int acc, input logic o);
        exp_t e;
        e.acc = acc[11:0];
        e.ovf = o;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int acc, input logic o);
        exp_t e;
        e.acc = acc[11:0];
        e.ovf = o;
        q_b.push_back(e);
    endtask

    // Apply inputs for exactly one clock edge, return just after that edge.
    task automatic cyc_a(input logic v, input logic [7:0] p, input logic c);
        a_if.in_valid = v;
        a_if.prod     = p;
        clr_a         = c;
        @(posedge CLK);
        #1;
        a_if.in_valid = 1'b0;
        clr_a         = 1'b0;
    endtask

    task automatic cyc_b(input logic v, input logic [7:0] p);
        b_if.in_valid = v;
        b_if.prod     = p;
        @(posedge CLK);
        #1;
        b_if.in_valid = 1'b0;
    endtask

    // Scoreboard monitors: sample on the falling edge, pop on each hand-over.
    always @(negedge CLK) begin
        if (!RST && a_if.out_valid && a_if.out_ready) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_acc_out", 32'(a_if.acc_out), 32'(e.acc));
                check("a_ovf", 32'(a_if.ovf), 32'(e.ovf));
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST && b_if.out_valid && b_if.out_ready) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_acc_out", 32'(b_if.acc_out), 32'(e.acc));
                check("b_ovf", 32'(b_if.ovf), 32'(e.ovf));
            end
        end
    end

    // Watchdog: the sequence below is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        RST = 1'b1;
        clr_a = 1'b0;
        clr_b = 1'b0;
        a_if.in_valid = 1'b0;
        a_if.prod = 8'd0;
        a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0;
        b_if.prod = 8'd0;
        b_if.out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state.
        check("rst_in_ready", 32'(a_if.in_ready), 32'd1);
        check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_acc_out", 32'(a_if.acc_out), 32'd0);
        check("rst_ovf", 32'(a_if.ovf), 32'd0);
        check("rst_b_in_ready", 32'(b_if.in_ready), 32'd1);

        // Basic burst; result valid right after the 4th accept, for one cycle.
        push_a(110, 1'b0);
        cyc_a(1'b1, 8'd15, 1'b0);
        cyc_a(1'b1, 8'd14, 1'b0);
        cyc_a(1'b1, 8'd81, 1'b0);
        cyc_a(1'b1, 8'd0, 1'b0);
        check("basic_out_valid", 32'(a_if.out_valid), 32'd1);
        check("basic_in_ready_hold", 32'(a_if.in_ready), 32'd0);
        // A product offered during the hand-over cycle is not taken.
        push_a(4, 1'b0);
        cyc_a(1'b1, 8'd1, 1'b0);
        check("basic_out_valid_drop", 32'(a_if.out_valid), 32'd0);
        check("basic_in_ready_back", 32'(a_if.in_ready), 32'd1);
        repeat (4) cyc_a(1'b1, 8'd1, 1'b0);
        cyc_a(1'b0, 8'd0, 1'b0);

        // Largest products.
        push_a(900, 1'b0);
        repeat (4) cyc_a(1'b1, 8'd225, 1'b0);
        cyc_a(1'b0, 8'd0, 1'b0);

        // Backpressure; clr during hold must not disturb the result.
        a_if.out_ready = 1'b0;
        push_a(26, 1'b0);
        cyc_a(1'b1, 8'd5, 1'b0);
        cyc_a(1'b1, 8'd6, 1'b0);
        cyc_a(1'b1, 8'd7, 1'b0);
        cyc_a(1'b1, 8'd8, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc_a(1'b1, 8'd99, (i == 2) ? 1'b1 : 1'b0);
            check("bp_out_valid", 32'(a_if.out_valid), 32'd1);
            check("bp_acc_out", 32'(a_if.acc_out), 32'd26);
            check("bp_in_ready", 32'(a_if.in_ready), 32'd0);
        end
        a_if.out_ready = 1'b1;
        cyc_a(1'b0, 8'd0, 1'b0);
        push_a(4, 1'b0);
        repeat (4) cyc_a(1'b1, 8'd1, 1'b0);
        cyc_a(1'b0, 8'd0, 1'b0);

        // Gaps and clr: the clr cycle's product is dropped.
        push_a(10, 1'b0);
        cyc_a(1'b1, 8'd10, 1'b0);
        cyc_a(1'b0, 8'd0, 1'b0);
        cyc_a(1'b1, 8'd20, 1'b0);
        cyc_a(1'b1, 8'd50, 1'b1);
        check("clr_in_ready", 32'(a_if.in_ready), 32'd1);
        cyc_a(1'b1, 8'd1, 1'b0);
        cyc_a(1'b1, 8'd2, 1'b0);
        cyc_a(1'b1, 8'd3, 1'b0);
        cyc_a(1'b1, 8'd4, 1'b0);
        cyc_a(1'b0, 8'd0, 1'b0);

        // Reset mid-burst.
        cyc_a(1'b1, 8'd3, 1'b0);
        cyc_a(1'b1, 8'd3, 1'b0);
        RST = 1'b1;
        cyc_a(1'b0, 8'd0, 1'b0);
        RST = 1'b0;
        check("rst_mid_out_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(a_if.in_ready), 32'd1);

        // Reset while holding a result.
        a_if.out_ready = 1'b0;
        repeat (4) cyc_a(1'b1, 8'd7, 1'b0);
        check("rst_hold_pre_valid", 32'(a_if.out_valid), 32'd1);
        RST = 1'b1;
        cyc_a(1'b0, 8'd0, 1'b0);
        RST = 1'b0;
        check("rst_hold_out_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_hold_acc_out", 32'(a_if.acc_out), 32'd0);
        check("rst_hold_ovf", 32'(a_if.ovf), 32'd0);
        check("rst_hold_in_ready", 32'(a_if.in_ready), 32'd1);
        a_if.out_ready = 1'b1;
        push_a(20, 1'b0);
        repeat (4) cyc_a(1'b1, 8'd5, 1'b0);
        cyc_a(1'b0, 8'd0, 1'b0);

        // Overflow on the LEN=32 instance, then a clean burst.
        push_b(3104, 1'b1);
        repeat (32) cyc_b(1'b1, 8'd225);
        cyc_b(1'b0, 8'd0);
        push_b(32, 1'b0);
        repeat (32) cyc_b(1'b1, 8'd1);
        cyc_b(1'b0, 8'd0);

        repeat (2) @(posedge CLK);
        #1;
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
